doorbell_irq_ctrl: RTL and testbench

- Sits directly downstream of the FPU/SIMD interrupt mux, in the host controller interface (HCI).
- Turns the muxed completion level (fpu_ready_hci) and its 4-bit exception flags (fpu_flags_hci) into discrete completion events, queued in a small FIFO.
- Drives a registered doorbell interrupt to the host until every event has been popped.
- Tags each event with the unit that produced it (SIMD or scalar FPU).

---
 rtl/hci_pkg.sv | 21 ++
 rtl/doorbell_irq_ctrl_if.sv | 30 +++
 rtl/hci_evt_fifo.sv | 61 ++++++
 rtl/doorbell_irq_ctrl.sv | 92 +++++++++
 tb/tb_doorbell_irq_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hci_pkg.sv
// rtl/hci_pkg.sv - shared HCI event types, source tags and doorbell state encoding
package hci_pkg;

  localparam int FLAG_W = 4;

  localparam logic SRC_SIMD = 1'b1;
  localparam logic SRC_FPU  = 1'b0;

  typedef struct packed {
    logic              src;
    logic [FLAG_W-1:0] flags;
  } hci_evt_t;

  localparam int EVT_W = $bits(hci_evt_t);

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } db_state_t;

endpackage

// File: rtl/doorbell_irq_ctrl_if.sv
// rtl/doorbell_irq_ctrl_if.sv - completion-event and host-side signals of the doorbell controller
interface doorbell_irq_ctrl_if #(
  parameter int CNT_W = 3
);
  import hci_pkg::*;

  logic              fpu_ready_hci;
  logic [FLAG_W-1:0] fpu_flags_hci;
  logic              fpu_simd;
  logic              irq_en;
  logic              evt_rd_en;
  logic              ovf_clr;
  logic              evt_valid;
  logic [FLAG_W-1:0] evt_flags;
  logic              evt_src;
  logic [CNT_W-1:0]  evt_count;
  logic              overflow;
  logic              doorbell_irq;

  modport slave (
    input  fpu_ready_hci, fpu_flags_hci, fpu_simd, irq_en, evt_rd_en, ovf_clr,
    output evt_valid, evt_flags, evt_src, evt_count, overflow, doorbell_irq
  );

  modport master (
    output fpu_ready_hci, fpu_flags_hci, fpu_simd, irq_en, evt_rd_en, ovf_clr,
    input  evt_valid, evt_flags, evt_src, evt_count, overflow, doorbell_irq
  );

endinterface

// File: rtl/hci_evt_fifo.sv
// rtl/hci_evt_fifo.sv - synchronous event FIFO with explicit count and first-word-fall-through head
module hci_evt_fifo
  import hci_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  hci_evt_t         din,
  output hci_evt_t         head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  hci_evt_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/doorbell_irq_ctrl.sv
// rtl/doorbell_irq_ctrl.sv - turns FPU/SIMD completion levels into queued events and a host doorbell
module doorbell_irq_ctrl
  import hci_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                rst,
  doorbell_irq_ctrl_if.slave bus
);

  logic      ready_q;
  logic      rise;
  logic      full;
  logic      empty;
  logic      drop;
  hci_evt_t  din;
  hci_evt_t  head;
  db_state_t state;

  assign rise = bus.fpu_ready_hci & ~ready_q;
  assign drop = rise & full & ~(bus.evt_rd_en & ~empty);

  always_comb begin
    din       = '0;
    din.src   = bus.fpu_simd;
    din.flags = bus.fpu_flags_hci;
  end

  hci_evt_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rise),
    .pop   (bus.evt_rd_en),
    .din   (din),
    .head  (head),
    .count (bus.evt_count),
    .full  (full),
    .empty (empty)
  );

  assign bus.evt_valid = ~empty;
  assign bus.evt_flags = head.flags;
  assign bus.evt_src   = head.src;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      ready_q <= bus.fpu_ready_hci;
      if (drop) begin
        bus.overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        bus.overflow <= 1'b0;
      end
    end
  end

  // The occupancy seen here already settled on the previous edge, so the
  // doorbell follows evt_valid by exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.doorbell_irq <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.irq_en && (bus.evt_count != '0)) begin
            state            <= RING;
            bus.doorbell_irq <= 1'b1;
          end
        end
        RING: begin
          if (!bus.irq_en || (bus.evt_count == '0)) begin
            state            <= IDLE;
            bus.doorbell_irq <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          bus.doorbell_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doorbell_irq_ctrl.sv
// tb/tb_doorbell_irq_ctrl.sv - self-checking bench for doorbell_irq_ctrl
module tb_doorbell_irq_ctrl;
  import hci_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  doorbell_irq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  doorbell_irq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a queue of events plus the host-visible status bits.
  hci_evt_t m_q[$];
  logic     m_ovf;
  logic     m_irq;
  logic     m_rdy_prev;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [3:0] fl;
    logic       s;
    logic       en;
    logic       rd;
    logic       clr;
    logic       e_valid;
    logic [3:0] e_flags;
    logic       e_src;
    int         e_count;
    logic       e_ovf;
    logic       e_irq;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic rdy, input logic [3:0] fl,
                            input logic s, input logic en, input logic rd, input logic clr);
    hci_evt_t e;
    logic     dropped;
    if (r) begin
      m_q.delete();
      m_ovf      = 1'b0;
      m_irq      = 1'b0;
      m_rdy_prev = 1'b0;
    end else begin
      m_irq   = en && (m_q.size() > 0);
      dropped = 1'b0;
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      if (rdy && !m_rdy_prev) begin
        e.src   = s;
        e.flags = fl;
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_rdy_prev = rdy;
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic [3:0] fl,
                      input logic s, input logic en, input logic rd, input logic clr);
    rst               = r;
    bus.fpu_ready_hci = rdy;
    bus.fpu_flags_hci = fl;
    bus.fpu_simd      = s;
    bus.irq_en        = en;
    bus.evt_rd_en     = rd;
    bus.ovf_clr       = clr;
    @(posedge clk);
    model_edge(r, rdy, fl, s, en, rd, clr);
    #1;
    chk("model_valid", bus.evt_valid, m_q.size() > 0);
    chk("model_flags", bus.evt_flags, (m_q.size() > 0) ? m_q[0].flags : 0);
    chk("model_src", bus.evt_src, (m_q.size() > 0) ? m_q[0].src : 0);
    chk("model_count", bus.evt_count, m_q.size());
    chk("model_ovf", bus.overflow, m_ovf);
    chk("model_irq", bus.doorbell_irq, m_irq);
  endtask

  task automatic pulse(input logic [3:0] fl, input logic s, input logic en);
    step(1'b0, 1'b1, fl, s, en, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, en, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_q.delete();
    m_ovf      = 1'b0;
    m_irq      = 1'b0;
    m_rdy_prev = 1'b0;
    //              rst rdy fl    s  en rd clr | vld flg   src cnt ovf irq
    vt[0] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0};

    // Reset, then idle for ten cycles.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_count", bus.evt_count, 0);
    chk("idle_irq", bus.doorbell_irq, 0);

    // Held level: one event, doorbell one cycle behind evt_valid.
    for (int i = 0; i < 9; i++) begin
      step(vt[i].rst, vt[i].rdy, vt[i].fl, vt[i].s, vt[i].en, vt[i].rd, vt[i].clr);
      chk($sformatf("vec%0d_valid", i), bus.evt_valid, vt[i].e_valid);
      chk($sformatf("vec%0d_flags", i), bus.evt_flags, vt[i].e_flags);
      chk($sformatf("vec%0d_src", i), bus.evt_src, vt[i].e_src);
      chk($sformatf("vec%0d_count", i), bus.evt_count, vt[i].e_count);
      chk($sformatf("vec%0d_ovf", i), bus.overflow, vt[i].e_ovf);
      chk($sformatf("vec%0d_irq", i), bus.doorbell_irq, vt[i].e_irq);
    end

    // Five pulses into a four-deep FIFO, then drain.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) pulse(4'(i), 1'(i % 2), 1'b1);
    chk("ovf_count", bus.evt_count, 4);
    chk("ovf_flag", bus.overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_flags", i), bus.evt_flags, i);
      chk($sformatf("drain%0d_src", i), bus.evt_src, i % 2);
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("drain_valid", bus.evt_valid, 0);
    chk("drain_irq_hold", bus.doorbell_irq, 1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain_irq_drop", bus.doorbell_irq, 0);

    // Full FIFO with push and pop on the same edge.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) pulse(4'(i), SRC_FPU, 1'b1);
    step(1'b0, 1'b1, 4'd9, SRC_SIMD, 1'b1, 1'b1, 1'b0);
    chk("fullpp_count", bus.evt_count, 4);
    chk("fullpp_ovf", bus.overflow, 0);
    chk("fullpp_head", bus.evt_flags, 2);

    // Masked interrupt, then re-enable.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(4'd3, SRC_SIMD, 1'b0);
    pulse(4'd6, SRC_FPU, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mask_count", bus.evt_count, 2);
    chk("mask_irq", bus.doorbell_irq, 0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("unmask_irq", bus.doorbell_irq, 1);

    // Drop beats clear, then reset with three queued and overflow set.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) pulse(4'(i), SRC_FPU, 1'b1);
    step(1'b0, 1'b1, 4'd7, SRC_FPU, 1'b1, 1'b0, 1'b1);
    chk("drop_wins", bus.overflow, 1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_pre_count", bus.evt_count, 3);
    chk("rst_pre_ovf", bus.overflow, 1);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_count", bus.evt_count, 0);
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_irq", bus.doorbell_irq, 0);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
